// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: reads the combinational instruction ROM at the
// current PC, buffers {pc, word} pairs in a small prefetch FIFO and presents
// the FIFO head to decode over valid/ready. A redirect flushes the FIFO and
// restarts fetch at the target address.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          AW       = 10
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          fetch_en,
  output logic [AW-1:0] rom_address,
  input  logic [31:0]   rom_data,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic [31:0]   pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  entry_t        fifo_q [DEPTH];
  entry_t        hold_q;
  entry_t        head;
  logic          push, pop;

  // Low address bits of the redirect target are dropped (word alignment).
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  // ROM address depends on the PC only, so decode backpressure never reaches it.
  assign rom_address = pc[AW+1:2];

  // Handshake qualifiers; redirect suppresses both push and pop.
  always_comb begin
    inst_valid = (count != '0);
    pop  = inst_valid & inst_ready & ~redirect;
    push = fetch_en & ~redirect & ((count < FULL) | pop);
  end

  // Head is read straight out of the FIFO; when empty, the last head is replayed.
  always_comb begin
    head    = inst_valid ? fifo_q[rd_ptr] : hold_q;
    inst    = head.word;
    inst_pc = head.pc;
  end

  // PC, pointers and occupancy; redirect wins over any push/pop.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage: captures the ROM word alongside the PC it was fetched from.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr] <= '{pc: pc, word: rom_data};
    end
  end

  // Remember the most recent valid head so empty-state outputs stay defined.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)        hold_q <= '0;
    else if (inst_valid) hold_q <= fifo_q[rd_ptr];
  end

endmodule
